// File: rtl/if_id_flush_stage.sv
// Fetch-to-decode stage: buffers fetch responses in a small FIFO, hands them to
// decode over valid/ready, and on flush discards the buffer plus every fetch
// response still in flight. Outstanding fetches are credit-limited to DEPTH.
module if_id_flush_stage #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_enable_i,
    input  logic        fetch_req_i,
    output logic        fetch_ready_o,
    input  logic        fetch_rsp_valid_i,
    input  logic [31:0] fetch_rsp_pc_i,
    input  logic [31:0] fetch_rsp_inst_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t          fifo [DEPTH];
    entry_t          head;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   cnt, out_cnt, drop_cnt;
    logic [CW:0]     credit_sum;
    logic            req_fire, rsp_ok, push, pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A request needs a slot reserved for its response: buffered plus in-flight
    // entries must stay below DEPTH, so a push can never hit a full FIFO.
    assign credit_sum    = {1'b0, out_cnt} + {1'b0, cnt};
    assign fetch_ready_o = !rst_i && !flush_enable_i && (credit_sum < (CW+1)'(DEPTH));
    assign req_fire      = fetch_req_i && fetch_ready_o;

    // A response with nothing outstanding is a protocol error; it is ignored
    // so the counters stay consistent.
    assign rsp_ok = fetch_rsp_valid_i && (out_cnt != '0);
    assign push   = rsp_ok && (drop_cnt == '0) && !flush_enable_i && !rst_i;

    assign head       = fifo[rd_ptr];
    assign id_valid_o = (cnt != '0) && !flush_enable_i;
    assign id_pc_o    = (cnt != '0) ? head.pc   : 32'h0;
    assign id_inst_o  = (cnt != '0) ? head.inst : NOP_INST;
    assign pop        = id_valid_o && id_ready_i;

    // Occupancy, pointers and the outstanding/drop credit counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt      <= '0;
            out_cnt  <= '0;
            drop_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (flush_enable_i) begin
            // Everything still in flight after this cycle belongs to the
            // flushed path and must be discarded on arrival.
            cnt      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            out_cnt  <= out_cnt - CW'(rsp_ok);
            drop_cnt <= out_cnt - CW'(rsp_ok);
        end else begin
            out_cnt <= out_cnt + CW'(req_fire) - CW'(rsp_ok);
            cnt     <= cnt + CW'(push) - CW'(pop);
            if (rsp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
        end
    end

    // FIFO storage; data needs no reset since cnt qualifies every read.
    always_ff @(posedge clk_i) begin
        if (push) fifo[wr_ptr] <= '{pc: fetch_rsp_pc_i, inst: fetch_rsp_inst_i};
    end

    a_rsp_without_req: assert property (@(posedge clk_i) disable iff (rst_i)
        fetch_rsp_valid_i |-> (out_cnt != '0))
        else $error("fetch response with no outstanding request");

endmodule

// File: tb/tb_if_id_flush_stage.sv
// Directed bench: stimulus pushes expected decode outputs into a queue, a
// negedge monitor pops and compares on every decode handshake.
module tb_if_id_flush_stage;
    logic        clk_i = 1'b0;
    logic        rst_i, flush_enable_i, fetch_req_i, fetch_ready_o;
    logic        fetch_rsp_valid_i, id_valid_o, id_ready_i;
    logic [31:0] fetch_rsp_pc_i, fetch_rsp_inst_i, id_pc_o, id_inst_o;

    int nchk = 0;
    int nfail = 0;
    logic [63:0] exp_q [$];

    if_id_flush_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_enable_i(flush_enable_i),
        .fetch_req_i(fetch_req_i), .fetch_ready_o(fetch_ready_o),
        .fetch_rsp_valid_i(fetch_rsp_valid_i), .fetch_rsp_pc_i(fetch_rsp_pc_i),
        .fetch_rsp_inst_i(fetch_rsp_inst_i), .id_valid_o(id_valid_o),
        .id_ready_i(id_ready_i), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0033} ^ 32'h00A50000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Set one cycle's inputs; a response marked 'show' is expected at decode.
    task automatic drive(input logic req, input logic rsp, input logic [31:0] pc,
                         input logic flush, input logic show);
        fetch_req_i       = req;
        fetch_rsp_valid_i = rsp;
        fetch_rsp_pc_i    = pc;
        fetch_rsp_inst_i  = inst_of(pc);
        flush_enable_i    = flush;
        if (rsp && show) exp_q.push_back({pc, inst_of(pc)});
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every decode handshake must match the next expected entry.
    always @(negedge clk_i) begin
        if (!rst_i && id_valid_o && id_ready_i) begin
            if (exp_q.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_pop: got pc %h, no entry expected", id_pc_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("pop_pc", id_pc_o, e[63:32]);
                chk("pop_inst", id_inst_o, e[31:0]);
            end
        end
    end

    initial begin
        rst_i = 1'b1; id_ready_i = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick(); tick();
        chk("ready_in_reset", 32'(fetch_ready_o), 32'd0);
        rst_i = 1'b0;
        #1;
        chk("rst_valid", 32'(id_valid_o), 32'd0);
        chk("rst_pc", id_pc_o, 32'h0);
        chk("rst_inst", id_inst_o, 32'h00000013);
        chk("rst_ready", 32'(fetch_ready_o), 32'd1);

        // Stream with decode always ready
        drive(1, 0, 0, 0, 0); chk("s_ready0", 32'(fetch_ready_o), 32'd1); tick();
        drive(1, 1, 32'h0, 0, 1); tick();
        drive(0, 1, 32'h4, 0, 1);
        chk("s_ready_credit", 32'(fetch_ready_o), 32'd0);
        chk("s_valid", 32'(id_valid_o), 32'd1); tick();
        drive(1, 0, 0, 0, 0); chk("s_pc4_next", id_pc_o, 32'h4); tick();
        drive(0, 1, 32'h8, 0, 1); tick();
        drive(0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0); tick();

        // Backpressure
        id_ready_i = 1'b0;
        drive(1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0); chk("b_ready1", 32'(fetch_ready_o), 32'd1); tick();
        drive(0, 1, 32'h10, 0, 1); chk("b_ready_out2", 32'(fetch_ready_o), 32'd0); tick();
        drive(0, 1, 32'h14, 0, 1); tick();
        drive(0, 0, 0, 0, 0);
        chk("b_ready_full", 32'(fetch_ready_o), 32'd0);
        chk("b_valid_full", 32'(id_valid_o), 32'd1);
        chk("b_head", id_pc_o, 32'h10);
        id_ready_i = 1'b1; tick();
        drive(0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        chk("b_ready_after", 32'(fetch_ready_o), 32'd1);
        chk("b_valid_after", 32'(id_valid_o), 32'd0);

        // Flush with two outstanding, FIFO empty
        drive(1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 0);
        chk("f_ready_flush", 32'(fetch_ready_o), 32'd0);
        chk("f_valid_flush", 32'(id_valid_o), 32'd0); tick();
        drive(0, 1, 32'h20, 0, 0); tick();
        drive(0, 1, 32'h24, 0, 0); chk("f_drop1_hidden", 32'(id_valid_o), 32'd0); tick();
        drive(1, 0, 0, 0, 0);
        chk("f_drop2_hidden", 32'(id_valid_o), 32'd0);
        chk("f_ready_post", 32'(fetch_ready_o), 32'd1); tick();
        drive(0, 1, 32'h100, 0, 1); tick();
        drive(0, 0, 0, 0, 0); chk("f_third_shown", id_pc_o, 32'h100); tick();
        drive(0, 0, 0, 0, 0); tick();

        // Flush coinciding with a response while an entry is buffered
        id_ready_i = 1'b0;
        drive(1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 1, 32'h30, 0, 0); tick();
        drive(0, 1, 32'h34, 1, 0);
        chk("g_valid_gated", 32'(id_valid_o), 32'd0); tick();
        drive(0, 0, 0, 0, 0);
        chk("g_empty", 32'(id_valid_o), 32'd0);
        chk("g_inst_nop", id_inst_o, 32'h00000013);
        chk("g_ready", 32'(fetch_ready_o), 32'd1);
        id_ready_i = 1'b1;
        // Flush with a response and one more still in flight
        drive(1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 1, 32'h40, 1, 0); tick();
        drive(0, 1, 32'h44, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        chk("g2_dropped", 32'(id_valid_o), 32'd0);
        chk("g2_ready", 32'(fetch_ready_o), 32'd1); tick();

        // Reset while drops are pending
        drive(1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 0); tick();
        drive(0, 1, 32'h50, 0, 0); tick();
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0); tick();
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk("r_valid", 32'(id_valid_o), 32'd0);
        chk("r_pc", id_pc_o, 32'h0);
        chk("r_inst", id_inst_o, 32'h00000013);
        chk("r_ready", 32'(fetch_ready_o), 32'd1);
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 1, 32'h200, 0, 1); tick();
        drive(0, 0, 0, 0, 0);
        chk("r_first_shown_valid", 32'(id_valid_o), 32'd1);
        chk("r_first_shown_pc", id_pc_o, 32'h200); tick();
        drive(0, 0, 0, 0, 0); tick(); tick();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
